fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 64'h0, fetch address loaded on reset.
REQ-002 Parameter NOP_IR, 32'h00000013, instruction word presented to decode on a bubble.
REQ-003 CLK  in  1  clock; all state updates on its rising edge.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 stall  in  1  decode data-hazard stall; decode cannot accept a new instruction.
REQ-006 EXE_BR_V  in  1  execute has resolved the pending control-transfer instruction this cycle.
REQ-007 EXE_BR_TAKEN  in  1  resolved control transfer is taken; always 1 for JAL/JALR.
REQ-008 EXE_BR_TARGET  in  64  resolved target address.
REQ-009 IMEM_RDY  in  1  instruction memory returns IMEM_DATA this cycle.
REQ-010 IMEM_DATA  in  32  instruction word, valid only when IMEM_RDY=1.
REQ-011 IMEM_REQ  out  1  fetch request to instruction memory.
REQ-012 IMEM_ADDR  out  64  fetch address; equals PC.
REQ-013 DE_IR  out  32  instruction latched for decode.
REQ-014 DE_NPC  out  64  fetch address of the instruction in DE_IR; decode adds branch/jump offsets to it.
REQ-015 DE_V  out  1  DE_IR/DE_NPC hold a valid instruction.

Function
REQ-016 State: PC[63:0]; FSM {FETCH, BR_WAIT}; one-entry skid buffer (SB_IR, SB_PC, SB_V); DE latch (DE_IR, DE_NPC, DE_V).
REQ-017 IMEM_REQ = (state==FETCH) && !SB_V && !RESET, combinationally.
REQ-018 Handshake: once asserted, IMEM_REQ and IMEM_ADDR hold stable until the cycle IMEM_RDY=1; IMEM_RDY while IMEM_REQ=0 is ignored.
REQ-019 Accept: IMEM_RDY && IMEM_REQ; on accept, PC <= PC+4 (64-bit wrap at 2^64).
REQ-020 Accept with stall=0 and SB_V=0: DE_IR <= IMEM_DATA, DE_NPC <= PC, DE_V <= 1 (zero added latency beyond the memory response).
REQ-021 Accept with stall=1: SB_IR <= IMEM_DATA, SB_PC <= PC, SB_V <= 1; DE latch holds.
REQ-022 stall=0 and SB_V=1: DE latch <= {SB_IR, SB_PC, 1}; SB_V <= 0; IMEM_REQ is 0 this cycle, so no simultaneous accept.
REQ-023 stall=0, no accept, SB_V=0: DE_V <= 0, DE_IR <= NOP_IR, DE_NPC holds.
REQ-024 stall=1: DE_IR, DE_NPC, DE_V hold regardless of any other input.
REQ-025 Control detect: accepted word with IMEM_DATA[6:2] in {5'b11000, 5'b11001, 5'b11011} moves FSM FETCH->BR_WAIT in the same edge, whether it goes to DE or the skid buffer.
REQ-026 BR_WAIT: no requests; PC holds (already branch PC+4).
REQ-027 BR_WAIT with EXE_BR_V=1: PC <= EXE_BR_TAKEN ? {EXE_BR_TARGET[63:2],2'b00} : PC; FSM -> FETCH; first request next cycle.
REQ-028 EXE_BR_V while stall=1 still redirects PC/FSM; DE latch holds per REQ-024.
REQ-029 EXE_BR_V in FETCH is ignored (no PC change).
REQ-030 No wrong-path fetch is ever issued: request for PC+4 after a control instruction is never generated before resolution.

Reset
REQ-031 RESET=1 at a rising edge: PC <= RESET_PC, FSM <= FETCH, SB_V <= 0, DE_V <= 0, DE_IR <= NOP_IR, DE_NPC <= RESET_PC.
REQ-032 RESET has priority over stall, IMEM_RDY and EXE_BR_V; an in-flight request is abandoned and a response in that cycle is dropped.
REQ-033 First IMEM_REQ at RESET_PC is asserted in the first cycle after RESET deasserts.

Verification
REQ-034 Reset release, IMEM_RDY=1 every cycle, words ADDI -> DE_NPC 0,4,8,... on consecutive cycles, DE_V=1 from cycle 1.
REQ-035 IMEM_RDY delayed 3 cycles at PC=0x10 -> IMEM_ADDR stays 0x10, DE_V=0 with DE_IR=0x00000013 for the wait, then DE_NPC=0x10.
REQ-036 stall=1 for 2 cycles while word at 0x20 returns -> DE holds 0x1C, 0x20 sits in skid buffer, IMEM_REQ=0; stall=0 -> DE_NPC=0x20 next edge, then request 0x24.
REQ-037 BEQ at 0x40, EXE_BR_V=1 TAKEN=1 TARGET=0x100 after 2 cycles -> no request 0x44, next IMEM_ADDR=0x100; same with TAKEN=0 -> next IMEM_ADDR=0x44.
REQ-038 JALR returns, TARGET=0x203 -> IMEM_ADDR=0x200.
REQ-039 RESET asserted during BR_WAIT with SB_V=1 and DE_V=1 -> next cycle DE_V=0, SB empty, IMEM_ADDR=RESET_PC, FSM FETCH.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus: request/address out of fetch, ready/data back from memory.
interface fetch_stage_if;
    logic        IMEM_REQ;
    logic [63:0] IMEM_ADDR;
    logic        IMEM_RDY;
    logic [31:0] IMEM_DATA;

    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_RDY,
        input  IMEM_DATA
    );

    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_RDY,
        output IMEM_DATA
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: issues in-order instruction fetches, buffers one word across a
// decode stall, and parks in BR_WAIT after any control transfer until execute
// resolves it, so no wrong-path fetch is ever issued.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_IR   = 32'h00000013
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 stall,
    input  logic                 EXE_BR_V,
    input  logic                 EXE_BR_TAKEN,
    input  logic [63:0]          EXE_BR_TARGET,
    fetch_stage_if.master        imem,
    output logic [31:0]          DE_IR,
    output logic [63:0]          DE_NPC,
    output logic                 DE_V
);

    typedef enum logic {
        FETCH   = 1'b0,
        BR_WAIT = 1'b1
    } state_t;

    state_t      state_q;
    logic [63:0] pc_q;
    logic [63:0] pc_d;

    logic [31:0] sb_ir_q;
    logic [63:0] sb_pc_q;
    logic        sb_v_q;

    logic [31:0] de_ir_q;
    logic [63:0] de_npc_q;
    logic        de_v_q;

    logic        imem_req;
    logic        accept;
    logic        ctrl_word;
    logic [63:0] br_target;

    // Target low bits are dropped: fetch addresses are always word aligned.
    logic        unused_target_bits;
    assign unused_target_bits = &{1'b0, EXE_BR_TARGET[1:0]};
    assign br_target          = {EXE_BR_TARGET[63:2], 2'b00};

    // Branch (11000), JALR (11001) and JAL (11011) major opcodes.
    function automatic logic is_ctrl(input logic [31:0] ir);
        return (ir[6:2] == 5'b11000) || (ir[6:2] == 5'b11001) || (ir[6:2] == 5'b11011);
    endfunction

    // A full skid buffer or a pending control transfer blocks new requests.
    assign imem_req  = (state_q == FETCH) && !sb_v_q && !RESET;
    assign accept    = imem.IMEM_RDY && imem_req;
    assign ctrl_word = is_ctrl(imem.IMEM_DATA);

    assign imem.IMEM_REQ  = imem_req;
    assign imem.IMEM_ADDR = pc_q;

    assign DE_IR  = de_ir_q;
    assign DE_NPC = de_npc_q;
    assign DE_V   = de_v_q;

    // Next PC: advance on accept in FETCH, redirect on resolution in BR_WAIT.
    always_comb begin
        pc_d = pc_q;
        if (state_q == FETCH) begin
            if (accept) begin
                pc_d = pc_q + 64'd4;
            end
        end else if (EXE_BR_V) begin
            pc_d = EXE_BR_TAKEN ? br_target : pc_q;
        end
    end

    // Fetch FSM and PC; resolution is honoured even while decode is stalled.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                FETCH: begin
                    if (accept && ctrl_word) begin
                        state_q <= BR_WAIT;
                    end
                end
                BR_WAIT: begin
                    if (EXE_BR_V) begin
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    // Skid buffer and decode latch: stalled responses park in the skid
    // buffer; the buffer drains into decode before any new request is made.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sb_v_q   <= 1'b0;
            sb_ir_q  <= NOP_IR;
            sb_pc_q  <= RESET_PC;
            de_v_q   <= 1'b0;
            de_ir_q  <= NOP_IR;
            de_npc_q <= RESET_PC;
        end else if (stall) begin
            if (accept) begin
                sb_ir_q <= imem.IMEM_DATA;
                sb_pc_q <= pc_q;
                sb_v_q  <= 1'b1;
            end
        end else if (sb_v_q) begin
            de_ir_q  <= sb_ir_q;
            de_npc_q <= sb_pc_q;
            de_v_q   <= 1'b1;
            sb_v_q   <= 1'b0;
        end else if (accept) begin
            de_ir_q  <= imem.IMEM_DATA;
            de_npc_q <= pc_q;
            de_v_q   <= 1'b1;
        end else begin
            de_ir_q <= NOP_IR;
            de_v_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, memory wait, stall/skid,
// branch resolution (taken / not taken / ignored in FETCH), JALR alignment,
// and reset while a control transfer is pending.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] BEQ  = 32'h00000063;
    localparam logic [31:0] JALR = 32'h00000067;
    localparam logic [31:0] JAL  = 32'h0000006f;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        stall;
    logic        EXE_BR_V;
    logic        EXE_BR_TAKEN;
    logic [63:0] EXE_BR_TARGET;
    logic [31:0] DE_IR;
    logic [63:0] DE_NPC;
    logic        DE_V;

    fetch_stage_if bus ();

    fetch_stage dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .stall        (stall),
        .EXE_BR_V     (EXE_BR_V),
        .EXE_BR_TAKEN (EXE_BR_TAKEN),
        .EXE_BR_TARGET(EXE_BR_TARGET),
        .imem         (bus),
        .DE_IR        (DE_IR),
        .DE_NPC       (DE_NPC),
        .DE_V         (DE_V)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle so registered outputs are visible.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One accepted ADDI-class word at the given address with no stall.
    task automatic fetch_word(input logic [63:0] addr, input logic [31:0] w);
        bus.IMEM_RDY  = 1'b1;
        bus.IMEM_DATA = w;
        #1;
        chk("req", {63'd0, bus.IMEM_REQ}, 64'd1);
        chk("addr", bus.IMEM_ADDR, addr);
        tick();
        chk("de_npc", DE_NPC, addr);
        chk("de_ir", {32'd0, DE_IR}, {32'd0, w});
        chk("de_v", {63'd0, DE_V}, 64'd1);
    endtask

    initial begin
        RESET         = 1'b1;
        stall         = 1'b0;
        EXE_BR_V      = 1'b0;
        EXE_BR_TAKEN  = 1'b0;
        EXE_BR_TARGET = 64'd0;
        bus.IMEM_RDY  = 1'b1;
        bus.IMEM_DATA = NOP;
        tick();
        tick();

        // Reset state
        chk("rst_de_v", {63'd0, DE_V}, 64'd0);
        chk("rst_de_ir", {32'd0, DE_IR}, {32'd0, NOP});
        chk("rst_de_npc", DE_NPC, 64'd0);
        chk("rst_req", {63'd0, bus.IMEM_REQ}, 64'd0);
        chk("rst_addr", bus.IMEM_ADDR, 64'd0);

        // Streaming ADDI words, one per cycle from reset release
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fetch_word(64'(4 * k), NOP | (32'(k) << 20));
        end

        // Memory holds off 3 cycles at 0x10
        bus.IMEM_RDY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wait_req", {63'd0, bus.IMEM_REQ}, 64'd1);
            chk("wait_addr", bus.IMEM_ADDR, 64'h10);
            tick();
            chk("wait_de_v", {63'd0, DE_V}, 64'd0);
            chk("wait_de_ir", {32'd0, DE_IR}, {32'd0, NOP});
            chk("wait_de_npc", DE_NPC, 64'h0C);
        end
        fetch_word(64'h10, 32'h00a00093);
        fetch_word(64'h14, 32'h00b00093);
        fetch_word(64'h18, 32'h00c00093);
        fetch_word(64'h1C, 32'h00d00093);

        // Stall while the word at 0x20 returns: it goes to the skid buffer
        stall         = 1'b1;
        bus.IMEM_RDY  = 1'b1;
        bus.IMEM_DATA = 32'h02000093;
        #1;
        chk("stall_addr", bus.IMEM_ADDR, 64'h20);
        tick();
        chk("stall1_de_npc", DE_NPC, 64'h1C);
        chk("stall1_de_v", {63'd0, DE_V}, 64'd1);
        chk("stall1_req", {63'd0, bus.IMEM_REQ}, 64'd0);
        bus.IMEM_DATA = 32'hdeadbeef;
        tick();
        chk("stall2_de_npc", DE_NPC, 64'h1C);
        chk("stall2_req", {63'd0, bus.IMEM_REQ}, 64'd0);
        stall = 1'b0;
        #1;
        chk("drain_req", {63'd0, bus.IMEM_REQ}, 64'd0);
        tick();
        chk("drain_de_npc", DE_NPC, 64'h20);
        chk("drain_de_ir", {32'd0, DE_IR}, 64'h02000093);
        chk("drain_de_v", {63'd0, DE_V}, 64'd1);
        for (int a = 'h24; a <= 'h3C; a += 4) begin
            fetch_word(64'(a), 32'h00100093);
        end

        // BEQ at 0x40, not taken: no fetch of 0x44 until resolution
        fetch_word(64'h40, BEQ);
        bus.IMEM_RDY = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("bw_req", {63'd0, bus.IMEM_REQ}, 64'd0);
            tick();
        end
        chk("bw_de_v", {63'd0, DE_V}, 64'd0);
        EXE_BR_V     = 1'b1;
        EXE_BR_TAKEN = 1'b0;
        EXE_BR_TARGET = 64'h300;
        #1;
        chk("res_req", {63'd0, bus.IMEM_REQ}, 64'd0);
        tick();
        EXE_BR_V = 1'b0;
        #1;
        chk("nt_req", {63'd0, bus.IMEM_REQ}, 64'd1);
        chk("nt_addr", bus.IMEM_ADDR, 64'h44);

        // BEQ at 0x44, taken to 0x100
        fetch_word(64'h44, BEQ);
        bus.IMEM_RDY = 1'b0;
        tick();
        tick();
        EXE_BR_V      = 1'b1;
        EXE_BR_TAKEN  = 1'b1;
        EXE_BR_TARGET = 64'h100;
        tick();
        EXE_BR_V = 1'b0;
        #1;
        chk("tk_req", {63'd0, bus.IMEM_REQ}, 64'd1);
        chk("tk_addr", bus.IMEM_ADDR, 64'h100);

        // Resolution while in FETCH is ignored
        EXE_BR_V      = 1'b1;
        EXE_BR_TARGET = 64'h500;
        tick();
        EXE_BR_V = 1'b0;
        #1;
        chk("ign_addr", bus.IMEM_ADDR, 64'h100);
        chk("ign_req", {63'd0, bus.IMEM_REQ}, 64'd1);

        // JALR at 0x100, target 0x203 resolves during a stall
        fetch_word(64'h100, JALR);
        bus.IMEM_RDY  = 1'b0;
        stall         = 1'b1;
        EXE_BR_V      = 1'b1;
        EXE_BR_TAKEN  = 1'b1;
        EXE_BR_TARGET = 64'h203;
        tick();
        EXE_BR_V = 1'b0;
        #1;
        chk("jalr_addr", bus.IMEM_ADDR, 64'h200);
        chk("jalr_req", {63'd0, bus.IMEM_REQ}, 64'd1);
        chk("jalr_de_npc", DE_NPC, 64'h100);
        chk("jalr_de_v", {63'd0, DE_V}, 64'd1);

        // JAL at 0x200 lands in the skid buffer: BR_WAIT, SB full, DE valid
        bus.IMEM_RDY  = 1'b1;
        bus.IMEM_DATA = JAL;
        tick();
        chk("jal_req", {63'd0, bus.IMEM_REQ}, 64'd0);
        chk("jal_de_v", {63'd0, DE_V}, 64'd1);
        chk("jal_addr", bus.IMEM_ADDR, 64'h204);

        // Reset overrides stall, a response and a resolution in the same cycle
        RESET         = 1'b1;
        EXE_BR_V      = 1'b1;
        EXE_BR_TARGET = 64'h800;
        tick();
        chk("r2_de_v", {63'd0, DE_V}, 64'd0);
        chk("r2_de_ir", {32'd0, DE_IR}, {32'd0, NOP});
        chk("r2_de_npc", DE_NPC, 64'd0);
        RESET        = 1'b0;
        stall        = 1'b0;
        EXE_BR_V     = 1'b0;
        bus.IMEM_RDY = 1'b0;
        #1;
        chk("r2_req", {63'd0, bus.IMEM_REQ}, 64'd1);
        chk("r2_addr", bus.IMEM_ADDR, 64'd0);
        tick();
        chk("r2_sb_empty_de_v", {63'd0, DE_V}, 64'd0);
        fetch_word(64'h0, 32'h00500093);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard bound on simulated time so the bench always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
